mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 bit-mux datapath among 8 requesters.
- Grants one requester at a time and drives the mux select and enable directly.
- Inserts a one-cycle dead gap between owners so the mux output never switches while enabled.
- Sits between the requesting units and the 8:1 mux instance.

Parameters:
- HOLD_MAX, 16, max consecutive GRANT cycles per owner. Used only when MUX_ARB_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit i = requester i (mux input A=0 .. H=7)
- grant  output  8  one-hot registered grant; all-zero when no owner
- Enable  output  1  mux enable; high only in GRANT
- sel  output  3  mux select in the mux's encoding: requester i -> sel = {i[0], i[1], i[2]} (bit-reversed index)
- owner  output  3  plain binary index of the current/last owner
- timeout  output  1  one-cycle pulse when an owner is pre-empted by the hold limit

Behaviour:
- All outputs and state are registered. No combinational path from req to any output.
- Reset (asynchronous, immediate, any state):
  - state=IDLE, grant=0, Enable=0, sel=0, owner=0, timeout=0.
  - Round-robin pointer ptr=7, so requester 0 wins first. Hold counter=0.
- States: IDLE, GRANT, GAP.
- Arbitration (evaluated in IDLE and GAP):
  - If req != 0: winner = first set bit searching ptr+1, ptr+2, ... modulo 8 (wraps 7->0).
  - Next state GRANT, grant=onehot(winner), owner=winner, sel=bitrev(winner), Enable=1, ptr=winner, counter=1.
  - If req == 0: next state IDLE, Enable=0, grant=0. sel/owner hold their last value.
- Latency: req sampled high at edge N in IDLE -> grant/Enable visible after edge N (1 cycle).
- GRANT:
  - Stays while req[owner]=1; other requests are ignored.
  - req[owner]=0 at an edge -> GAP: Enable=0, grant=0, sel/owner held.
- GAP:
  - Always exactly one cycle, then arbitration as above.
  - Handover latency: owner drops at edge N, next owner granted after edge N+1.
- Simultaneous events:
  - Owner drops while others request -> still passes through GAP; no direct GRANT->GRANT.
  - The same requester may win again only if no other request is pending (pointer rotation).
  - A requester that drops req in the same cycle it would win is not granted: arbitration uses sampled req only.
- Counter (8-bit) counts GRANT cycles, saturates at 255, and is cleared on each new grant.
- Invariants:
  - grant is one-hot or zero.
  - Enable == |grant.
  - grant[owner] == Enable.

Optional Feature:
- MUX_ARB_TIMEOUT_EN defined:
  - In GRANT, if counter == HOLD_MAX and req[owner] is still 1, the next edge forces GAP and timeout=1 for that single GAP cycle.
  - ptr is already the owner, so the next search starts at owner+1.
  - If the pre-empted requester is the only requester, it is re-granted after the GAP.
- MUX_ARB_TIMEOUT_EN undefined:
  - No hold limit; the owner keeps the mux indefinitely.
  - timeout is tied to 0. Counter logic may be omitted.
  - HOLD_MAX is ignored.

Test Plan:
- Reset, then req=8'h01 -> after 1 edge: grant=8'h01, sel=3'b000, Enable=1, owner=0. Drop req -> GAP 1 cycle, then IDLE with Enable=0.
- req=8'h02 alone -> grant=8'h02, owner=1, sel=3'b100 (bit-reversed mapping check against the real 8:1 mux: mux output equals input B).
- req=8'hFF held, each owner drops its bit for one cycle after 3 cycles of grant, then reasserts -> grant order 0,1,2,...,7,0. Each grant is separated by exactly one Enable=0 cycle.
- After owner 5, req=8'h21 (requesters 0 and 5) -> requester 0 wins (wrap-around), not 5.
- Macro defined, HOLD_MAX=4, req=8'h09 held constant -> owner 0 holds 4 cycles, GAP with timeout=1, owner 3 holds 4 cycles, GAP, owner 0 again. Macro undefined -> owner 0 holds forever and timeout stays 0.
- reset asserted mid-GRANT between clock edges -> Enable, grant and timeout go 0 immediately. After release with req=8'h80, the first grant goes to requester 7 (ptr restarted at 7, winner search from 0).

Source files
------------

// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the requesting units, the round-robin arbiter and the 8:1 bit-mux.
// The master modport is the arbiter side; the slave modport is the requester/mux side.
interface mux8_rr_arbiter_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic       Enable;
  logic [2:0] sel;
  logic [2:0] owner;
  logic       timeout;

  modport master (
    input  req,
    output grant,
    output Enable,
    output sel,
    output owner,
    output timeout
  );

  modport slave (
    output req,
    input  grant,
    input  Enable,
    input  sel,
    input  owner,
    input  timeout
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8:1 bit-mux among 8 requesters.
// Grants one owner at a time, drives the mux select/enable from flops, and inserts
// a one-cycle dead gap between owners so the mux never switches while enabled.
// Optional hold limit: define MUX_ARB_TIMEOUT_EN to pre-empt an owner after HOLD_MAX
// grant cycles (timeout pulses for the forced gap cycle).
module mux8_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  mux8_rr_arbiter_if.master         bus_io
);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] HoldMax = 8'(HOLD_MAX);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic       en_q, en_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       hold_hit;

  // The mux decodes its select with the index bits reversed.
  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  // Round-robin search: first set request at ptr+1, ptr+2, ... (ptr itself last).
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!win_found && bus_io.req[ptr_q + 3'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 3'(k);
      end
    end
  end

  // Constant zero when the hold limit is compiled out.
  assign hold_hit = TimeoutEn && (cnt_q == HoldMax);

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    en_d      = en_q;
    sel_d     = sel_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle, StGap: begin
        if (win_found) begin
          state_d = StGrant;
          grant_d = 8'h01 << win_idx;
          en_d    = 1'b1;
          owner_d = win_idx;
          sel_d   = bitrev3(win_idx);
          ptr_d   = win_idx;
          cnt_d   = 8'd1;
        end else begin
          state_d = StIdle;
          grant_d = 8'h00;
          en_d    = 1'b0;
        end
      end
      StGrant: begin
        if (!bus_io.req[owner_q] || hold_hit) begin
          // Owner released or was pre-empted: always pass through one dead cycle.
          state_d   = StGap;
          grant_d   = 8'h00;
          en_d      = 1'b0;
          timeout_d = bus_io.req[owner_q];
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 8'h00;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= 8'h00;
      en_q      <= 1'b0;
      sel_q     <= 3'd0;
      owner_q   <= 3'd0;
      ptr_q     <= 3'd7;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      en_q      <= en_d;
      sel_q     <= sel_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_io.grant   = grant_q;
  assign bus_io.Enable  = en_q;
  assign bus_io.sel     = sel_q;
  assign bus_io.owner   = owner_q;
  assign bus_io.timeout = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a behavioural model predicts the outputs after
// every clock edge into a queue; a monitor on the falling edge pops and compares.
module tb_mux8_rr_arbiter;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif
  localparam int HoldMax = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic       en;
    logic [2:0] sel;
    logic [2:0] owner;
    logic       to;
  } obs_t;

  logic clk;
  logic reset;
  mux8_rr_arbiter_if bus ();

  mux8_rr_arbiter #(.HOLD_MAX(HoldMax)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_owner;   // -1 when nobody holds the mux
  int m_last;    // last owner, shown on owner/sel
  int m_ptr;     // last winner for the rotation
  int m_cnt;     // grant cycles of the current owner
  bit m_to;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 7;
    m_cnt   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r);
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (TimeoutEn && m_cnt == HoldMax) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= 8; k++) begin
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_ptr   = w;
        m_cnt   = 1;
      end
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    logic [2:0] l;
    l       = 3'(m_last);
    o.grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    o.en    = (m_owner >= 0);
    o.owner = l;
    o.sel   = {l[0], l[1], l[2]};
    o.to    = m_to;
    return o;
  endfunction

  initial model_reset();

  // Predictor: advance the model on every edge that the DUT sees.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step(bus.req);
      exp_q.push_back(model_out());
    end
  end

  // Monitor: compare DUT outputs away from the active edge.
  always @(negedge clk) begin
    obs_t act, e;
    logic inv_ok;
    act = '{grant: bus.grant, en: bus.Enable, sel: bus.sel, owner: bus.owner, to: bus.timeout};
    if (reset) begin
      chk("reset_state", 32'(act), 32'd0);
    end else begin
      inv_ok = ($countones(bus.grant) <= 1) && (bus.Enable == |bus.grant)
               && (bus.grant[bus.owner] == bus.Enable);
      chk("invariants", 32'(inv_ok), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("scoreboard", 32'(act), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic reset_dut();
    @(negedge clk);
    #2 reset = 1'b1;
    bus.req = 8'h00;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int         hold;
    bit         prev_en;
    int         seen[$];
    int         n_to;
    logic [7:0] data;
    logic [2:0] s;

    reset   = 1'b1;
    bus.req = 8'h00;
    reset_dut();

    // Single requester 0, then release through the gap back to idle.
    @(negedge clk); bus.req = 8'h01;
    @(negedge clk);
    chk("first_grant", {bus.grant, bus.Enable, bus.sel, bus.owner}, {8'h01, 1'b1, 3'b000, 3'd0});
    bus.req = 8'h00;
    @(negedge clk); chk("gap_enable", 32'(bus.Enable), 32'd0);
    @(negedge clk); chk("idle_enable", 32'(bus.Enable), 32'd0);

    // Requester 1: select is bit-reversed, so the mux must pick input B.
    bus.req = 8'h02;
    @(negedge clk);
    chk("req1_grant", {bus.grant, bus.owner, bus.sel}, {8'h02, 3'd1, 3'b100});
    data = 8'($urandom);
    s    = bus.sel;
    chk("mux_picks_b", 32'(data[{s[0], s[1], s[2]}]), 32'(data[1]));
    bus.req = 8'h00;
    repeat (2) @(negedge clk);

    // All requesting; each owner releases for one cycle after three grant cycles.
    reset_dut();
    bus.req = 8'hFF;
    hold    = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 120 && seen.size() < 9; c++) begin
      @(negedge clk);
      if (bus.Enable && !prev_en) seen.push_back(int'(bus.owner));
      prev_en = bus.Enable;
      if (bus.Enable) begin
        hold++;
        if (hold == 3) begin
          bus.req = 8'hFF & ~(8'h01 << bus.owner);
          hold    = 0;
        end else begin
          bus.req = 8'hFF;
        end
      end else begin
        bus.req = 8'hFF;
        hold    = 0;
      end
    end
    chk("ff_grant_count", 32'(seen.size()), 32'd9);
    foreach (seen[i]) chk("ff_grant_order", 32'(seen[i]), 32'(i % 8));

    // Wrap-around: after owner 5, requesters 0 and 5 pending -> 0 wins.
    reset_dut();
    @(negedge clk); bus.req = 8'h20;
    @(negedge clk); chk("owner5", 32'(bus.owner), 32'd5);
    bus.req = 8'h00;
    @(negedge clk); bus.req = 8'h21;
    @(negedge clk); chk("wrap_to_0", {bus.grant, bus.owner}, {8'h01, 3'd0});
    bus.req = 8'h00;
    repeat (2) @(negedge clk);

    // Constant 0 and 3 requesting: hold limit behaviour (or none).
    reset_dut();
    bus.req = 8'h09;
    n_to    = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.timeout) n_to++;
    end
    chk("timeout_count", 32'(n_to), TimeoutEn ? 32'd4 : 32'd0);
    bus.req = 8'h00;
    repeat (2) @(negedge clk);

    // Randomized traffic, requests mostly stable so owners get to hold.
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) bus.req = 8'h00;
      else if ($urandom_range(3) == 0) bus.req = 8'($urandom);
    end

    // Asynchronous reset in the middle of a grant.
    bus.req = 8'h0F;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 chk("async_reset", {bus.grant, bus.Enable, bus.timeout}, 32'd0);
    bus.req = 8'h80;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_grant7", {bus.grant, bus.owner}, {8'h80, 3'd7});
    bus.req = 8'h00;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
